memory_arbiter: RTL and testbench

Two-port arbiter sharing the single main-memory block port between the instruction cache (read-only) and the data cache (read/write). It serialises block refills and write-backs, alternates grants when both caches miss in the same cycle, and returns each requester its own `busywait` so the fetch unit and the memory stage stall independently. It sits between the two caches and main memory; the fetch unit's combined stall is unchanged because each cache's `busywait` still reflects its own miss.

---
 rtl/memory_arbiter.sv | 87 ++++++++
 tb/tb_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the main-memory block port between icache and dcache
module memory_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_busywait,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_busywait
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t state, state_n;
   logic owner, owner_n, started, started_n, last_grant, last_grant_n;
   logic [DATA_W-1:0] i_rd_q, i_rd_n, d_rd_q, d_rd_n;
   logic i_req, d_req, active;
   assign i_req = i_read;
   assign d_req = d_read | d_write;
   assign active = state == ACTIVE;
   // the icache only ever reads; a dcache read+write pair is a write-back
   assign mem_read = active & (!owner | (d_read & !d_write));
   assign mem_write = active & owner & d_write;
   assign mem_address = !active ? '0 : owner ? d_address : i_address;
   assign mem_writedata = (active & owner) ? d_writedata : '0;
   assign i_busywait = i_req & !(state == DONE & !owner);
   assign d_busywait = d_req & !(state == DONE & owner);
   assign i_readdata = i_rd_q;
   assign d_readdata = d_rd_q;
   // arbiter state and returned refill blocks
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         started <= 1'b0;
         last_grant <= 1'b1;
         i_rd_q <= '0;
         d_rd_q <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         started <= started_n;
         last_grant <= last_grant_n;
         i_rd_q <= i_rd_n;
         d_rd_q <= d_rd_n;
      end
   end
   // grant, wait for memory to go busy then idle, then one release cycle
   always_comb begin
      state_n = state;
      owner_n = owner;
      started_n = started;
      last_grant_n = last_grant;
      i_rd_n = i_rd_q;
      d_rd_n = d_rd_q;
      case (state)
         IDLE: if (i_req | d_req) begin
            owner_n = (i_req & d_req) ? !last_grant : d_req;
            started_n = 1'b0;
            state_n = ACTIVE;
         end
         ACTIVE: if (mem_busywait) started_n = 1'b1;
         else if (started) begin
            state_n = DONE;
            if (!owner) i_rd_n = mem_readdata;
            else if (!d_write) d_rd_n = mem_readdata;
         end
         DONE: begin
            state_n = IDLE;
            last_grant_n = owner;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks against a transaction-level model
module tb_memory_arbiter;
   logic clock = 1'b0, reset;
   logic i_read, d_read, d_write, mem_read, mem_write, mem_busywait, i_busywait, d_busywait;
   logic [27:0] i_address, d_address, mem_address;
   logic [127:0] i_readdata, d_readdata, d_writedata, mem_writedata, mem_readdata;
   int checks = 0, failures = 0;
   localparam logic [127:0] CAFE = 128'hCAFE;
   memory_arbiter dut (
      .clock(clock), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );
   always #5 clock = ~clock;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask
   task automatic chkb(input string nm, input logic act, input logic exp);
      chk(nm, {127'b0, act}, {127'b0, exp});
   endtask
   // main memory: busy for a latency after seeing a command, then one ack cycle
   int mph, cnt, lat = 5;
   bit mem_dead = 0, rand_data = 0, rand_lat = 0;
   logic [127:0] rd_next;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mph <= 0; cnt <= 0; mem_busywait <= 1'b0; mem_readdata <= '0; rd_next <= '0;
      end else if (mph == 0) begin
         if ((mem_read || mem_write) && !mem_dead) begin
            mph <= 1; mem_busywait <= 1'b1;
            cnt <= rand_lat ? int'($urandom_range(1, 4)) : lat;
            rd_next <= rand_data ? {$urandom, $urandom, $urandom, $urandom} : CAFE;
         end
      end else if (mph == 1) begin
         if (cnt <= 1) begin
            mph <= 2; mem_busywait <= 1'b0;
            if (mem_read) mem_readdata <= rd_next;
         end else cnt <= cnt - 1;
      end else mph <= 0;
   end
   // arbiter model: one transaction at a time, ends one cycle after the memory acks
   bit m_busy, m_done, m_d, m_last;
   logic [127:0] m_ird, m_drd;
   bit m_grants[$];
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_done = 0; m_d = 0; m_last = 1; m_ird = '0; m_drd = '0; m_grants.delete();
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_busy) begin
         if (mph == 2) begin
            m_done = 1;
            if (!m_d) m_ird = mem_readdata;
            else if (!d_write) m_drd = mem_readdata;
         end
      end else if (i_read || d_read || d_write) begin
         m_d = (i_read && (d_read || d_write)) ? !m_last : !i_read;
         m_last = m_d; m_busy = 1; m_grants.push_back(m_d);
      end
   end
   // every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
      if (!reset) begin
         automatic bit act = m_busy && !m_done;
         chkb("mem_read", mem_read, act && (!m_d || (d_read && !d_write)));
         chkb("mem_write", mem_write, act && m_d && d_write);
         chk("mem_address", 128'(mem_address), act ? 128'(m_d ? d_address : i_address) : '0);
         chk("mem_writedata", mem_writedata, (act && m_d) ? d_writedata : '0);
         chkb("i_busywait", i_busywait, i_read && !(m_done && !m_d));
         chkb("d_busywait", d_busywait, (d_read || d_write) && !(m_done && m_d));
         chk("i_readdata", i_readdata, m_ird);
         chk("d_readdata", d_readdata, m_drd);
      end
   end
   // grant order as seen on the memory port
   bit dut_grants[$];
   bit prev_cmd;
   always @(negedge clock or posedge reset) begin
      if (reset) begin
         dut_grants.delete(); prev_cmd = 0;
      end else begin
         if ((mem_read || mem_write) && !prev_cmd) dut_grants.push_back(mem_address == d_address);
         prev_cmd = mem_read || mem_write;
      end
   end
   task automatic wait_low(input bit s, output int hi);
      hi = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (!(s ? d_busywait : i_busywait)) return;
         hi++;
      end
      checks++; failures++;
      $display("FAIL busywait_timeout side=%0d actual=stuck required=release", s);
   endtask
   task automatic step;
      @(posedge clock); #1;
   endtask
   int hi, gap;
   initial begin
      reset = 1; i_read = 0; d_read = 0; d_write = 0;
      i_address = '0; d_address = '0; d_writedata = '0;
      #1 chkb("rst_mem_read", mem_read, 0);
      chkb("rst_i_busywait", i_busywait, 0);
      repeat (2) @(posedge clock);
      #1 reset = 0;
      chk("rst_i_readdata", i_readdata, '0);
      chk("rst_d_readdata", d_readdata, '0);
      i_read = 1; i_address = 28'h0000010;
      #1 chkb("t1_pre_grant", mem_read, 0);
      step;
      chkb("t1_mem_read", mem_read, 1);
      chk("t1_addr", 128'(mem_address), 128'h10);
      wait_low(0, hi);
      chk("t1_latency", 128'(hi + 1), 128'd8);
      step;
      chk("t1_i_readdata", i_readdata, CAFE);
      chkb("t1_one_cycle_low", i_busywait, 1);
      i_read = 0;
      d_write = 1; d_address = 28'h0ABCDE0; d_writedata = {4{32'hA5A5A5A5}};
      step;
      chkb("t2_mem_write", mem_write, 1);
      chkb("t2_mem_read", mem_read, 0);
      chk("t2_wdata", mem_writedata, {4{32'hA5A5A5A5}});
      chk("t2_addr", 128'(mem_address), 128'h0ABCDE0);
      wait_low(1, hi);
      step;
      d_write = 0;
      chk("t2_d_readdata", d_readdata, '0);
      reset = 1; #2 reset = 0;
      step;
      i_read = 1; i_address = 28'h100; d_read = 1; d_address = 28'h200;
      for (int k = 0; k < 300 && dut_grants.size() < 4; k++) @(negedge clock);
      for (int k = 0; k < 100 && (mem_read || mem_write); k++) @(negedge clock);
      step;
      i_read = 0; d_read = 0;
      step; step;
      chk("t3_ngrants", 128'(dut_grants.size()), 128'd4);
      chk("t3_model_ngrants", 128'(m_grants.size()), 128'd4);
      for (int k = 0; k < 4 && k < dut_grants.size(); k++) begin
         chkb($sformatf("t3_grant%0d", k), dut_grants[k], k[0]);
         chkb($sformatf("t3_model_grant%0d", k), m_grants[k], k[0]);
      end
      d_read = 1; d_write = 1; d_address = 28'h300; d_writedata = {$urandom, $urandom, $urandom, $urandom};
      step;
      chkb("t4_mem_write", mem_write, 1);
      chkb("t4_mem_read", mem_read, 0);
      wait_low(1, hi);
      step;
      d_read = 0; d_write = 0;
      chk("t4_d_readdata_kept", d_readdata, CAFE);
      i_read = 1; i_address = 28'h40;
      step; step;
      @(posedge clock); #2 reset = 1;
      #1 chkb("t5_mem_read_drop", mem_read, 0);
      chk("t5_i_readdata", i_readdata, '0);
      chk("t5_d_readdata", d_readdata, '0);
      chkb("t5_i_busywait", i_busywait, 1);
      chkb("t5_d_busywait", d_busywait, 0);
      step;
      reset = 0;
      wait_low(0, hi);
      chk("t5_latency", 128'(hi), 128'd8);
      step;
      chk("t5_i_readdata_again", i_readdata, CAFE);
      i_read = 0;
      step;
      i_read = 1; i_address = 28'h50;
      step;
      d_read = 1; d_address = 28'h60;
      step; step;
      i_read = 0;
      gap = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (!(mem_read || mem_write)) gap++;
         else if (gap > 0) break;
      end
      chk("t6_gap", 128'(gap), 128'd2);
      chk("t6_d_addr", 128'(mem_address), 128'h60);
      chk("t6_i_readdata", i_readdata, CAFE);
      wait_low(1, hi);
      step;
      d_read = 0;
      mem_dead = 1; i_read = 1; i_address = 28'h70;
      repeat (20) step;
      chkb("t7_stuck_mem_read", mem_read, 1);
      chkb("t7_stuck_busywait", i_busywait, 1);
      reset = 1;
      #1 chkb("t7_reset_drop", mem_read, 0);
      i_read = 0; mem_dead = 0;
      step;
      reset = 0;
      rand_data = 1; rand_lat = 1;
      fork
         begin : ag_i
            bit low;
            int k;
            k = 0;
            while ((k < 1500 || i_read) && k < 3000) begin
               @(negedge clock); low = i_read && !i_busywait;
               step; k++;
               if (low) begin
                  i_read = k < 1500 && $urandom_range(0, 3) == 0;
                  i_address = 28'($urandom);
               end else if (!i_read && k < 1500 && $urandom_range(0, 2) == 0) begin
                  i_read = 1; i_address = 28'($urandom);
               end
            end
         end
         begin : ag_d
            bit low;
            int k, op;
            k = 0;
            while ((k < 1500 || d_read || d_write) && k < 3000) begin
               @(negedge clock); low = (d_read || d_write) && !d_busywait;
               step; k++;
               if (low || (!d_read && !d_write && k < 1500 && $urandom_range(0, 2) == 0)) begin
                  op = (k < 1500 && (!low || $urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 3)) : 0;
                  d_read = op[0]; d_write = op[1];
                  d_address = 28'($urandom);
                  d_writedata = {$urandom, $urandom, $urandom, $urandom};
               end
            end
         end
      join
      chkb("rand_i_drained", i_read, 0);
      chkb("rand_d_drained", d_read || d_write, 0);
      repeat (4) step;
      chk("rand_ngrants", 128'(dut_grants.size()), 128'(m_grants.size()));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
